// File: rtl/spi_reg_ctrl.sv
// SPI slave transaction controller: one CS frame = command byte {rw, addr} then a
// burst of register writes or prefetched register reads with address auto-increment.
module spi_reg_ctrl #(
   parameter int ADDR_W = 7,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cs_active,
   input  logic              rx_valid,
   input  logic [7:0]        rx_byte,
   output logic [7:0]        tx_byte,
   output logic              tx_load,
   output logic [ADDR_W-1:0] reg_addr,
   output logic [7:0]        reg_wdata,
   output logic              reg_we,
   output logic              reg_re,
   input  logic [7:0]        reg_rdata,
   output logic              busy,
   output logic              ovr_err,
   input  logic              ovr_clr
);

   typedef enum logic [2:0] {IDLE, CMD, WR, RD_REQ, RD_WAIT, RD_DATA} state_t;

   localparam logic [1:0] LAST_CNT = 2'(RD_LAT - 1);

   state_t            state, state_nxt;
   logic              armed;
   logic [1:0]        wait_cnt;
   logic [ADDR_W-1:0] addr;
   logic              wait_last;
   logic              we_d, re_d, load_d, cmd_latch, addr_inc, ovr_set;

   assign wait_last = (wait_cnt == LAST_CNT);
   assign reg_addr  = addr;
   assign busy      = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Losing CS outranks everything else, including a byte strobe in the same cycle.
   always_comb begin
      state_nxt = state;
      if (state != IDLE && !cs_active) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    if (cs_active && armed) state_nxt = CMD;
            CMD:     if (rx_valid) state_nxt = rx_byte[7] ? RD_REQ : WR;
            WR:      state_nxt = WR;
            RD_REQ:  state_nxt = RD_WAIT;
            RD_WAIT: if (wait_last) state_nxt = RD_DATA;
            RD_DATA: if (rx_valid) state_nxt = RD_REQ;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      we_d      = 1'b0;
      load_d    = 1'b0;
      cmd_latch = 1'b0;
      ovr_set   = 1'b0;
      if (cs_active) begin
         case (state)
            CMD:     cmd_latch = rx_valid;
            WR:      we_d      = rx_valid;
            RD_REQ:  ovr_set   = rx_valid;
            RD_WAIT: begin
               ovr_set = rx_valid;
               load_d  = wait_last;
            end
            default: ;
         endcase
      end
      re_d     = (state_nxt == RD_REQ);
      addr_inc = reg_we | load_d;
   end

   // Strobes are registered; the address steps after each write and with each read load.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_byte   <= 8'h00;
         tx_load   <= 1'b0;
         reg_wdata <= 8'h00;
         reg_we    <= 1'b0;
         reg_re    <= 1'b0;
         addr      <= '0;
         wait_cnt  <= 2'd0;
         ovr_err   <= 1'b0;
         armed     <= 1'b0;
      end else begin
         tx_load <= load_d;
         reg_we  <= we_d;
         reg_re  <= re_d;
         if (load_d) tx_byte <= reg_rdata;
         if (we_d)   reg_wdata <= rx_byte;
         if (cmd_latch)     addr <= rx_byte[ADDR_W-1:0];
         else if (addr_inc) addr <= addr + 1'b1;
         if (state == RD_WAIT) wait_cnt <= wait_cnt + 2'd1;
         else                  wait_cnt <= 2'd0;
         if (ovr_clr)      ovr_err <= 1'b0;
         else if (ovr_set) ovr_err <= 1'b1;
         // After reset a frame already in progress is ignored until CS goes idle.
         if (!cs_active) armed <= 1'b1;
      end
   end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Scoreboard bench for spi_reg_ctrl: stimulus pushes expected register/TX events,
// a negedge monitor pops and compares whenever the DUT strobes reg_we, reg_re or tx_load.
module tb_spi_reg_ctrl;

   localparam int RD_LAT = 3;
   localparam int GAP    = 10;
   localparam int K_WE   = 0;
   localparam int K_RE   = 1;
   localparam int K_LD   = 2;

   typedef struct {
      int         kind;
      logic [7:0] addr;
      logic [7:0] data;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cs_active = 1'b0;
   logic       rx_valid = 1'b0;
   logic [7:0] rx_byte = 8'h00;
   logic [7:0] tx_byte;
   logic       tx_load;
   logic [6:0] reg_addr;
   logic [7:0] reg_wdata;
   logic       reg_we;
   logic       reg_re;
   logic [7:0] reg_rdata;
   logic       busy;
   logic       ovr_err;
   logic       ovr_clr = 1'b0;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   lat;

   logic [7:0] rd_pipe [0:RD_LAT-1];

   spi_reg_ctrl #(.ADDR_W(7), .RD_LAT(RD_LAT)) dut (
      .clk(clk), .rst_n(rst_n), .cs_active(cs_active), .rx_valid(rx_valid),
      .rx_byte(rx_byte), .tx_byte(tx_byte), .tx_load(tx_load), .reg_addr(reg_addr),
      .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re), .reg_rdata(reg_rdata),
      .busy(busy), .ovr_err(ovr_err), .ovr_clr(ovr_clr)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] rd_model(input logic [6:0] a);
      case (a)
         7'h10:   return 8'h3C;
         7'h11:   return 8'h5A;
         7'h12:   return 8'h77;
         default: return {1'b0, a} ^ 8'hA5;
      endcase
   endfunction

   // Register file read port: data appears RD_LAT cycles after reg_re, filler otherwise.
   always @(posedge clk) begin
      rd_pipe[0] <= reg_re ? rd_model(reg_addr) : 8'hEE;
      for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign reg_rdata = rd_pipe[RD_LAT-1];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic string kname(input int k);
      return (k == K_WE) ? "reg_we" : (k == K_RE) ? "reg_re" : "tx_load";
   endfunction

   task automatic sb_check(input int kind, input logic [7:0] a, input logic [7:0] d);
      exp_t e;
      n_cmp++;
      if (sb.size() == 0) begin
         n_bad++;
         $display("FAIL unexpected_%s: got addr %0h data %0h, expected no access", kname(kind), a, d);
         return;
      end
      e = sb.pop_front();
      if (e.kind != kind || (kind != K_LD && e.addr != a) || (kind != K_RE && e.data != d)) begin
         n_bad++;
         $display("FAIL sb_%s: got %s addr %0h data %0h, expected %s addr %0h data %0h",
                  kname(kind), kname(kind), a, d, kname(e.kind), e.addr, e.data);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (reg_we || reg_re) check("we_re_exclusive", {31'd0, reg_we & reg_re}, 32'd0);
         if (reg_we)  sb_check(K_WE, {1'b0, reg_addr}, reg_wdata);
         if (reg_re)  sb_check(K_RE, {1'b0, reg_addr}, 8'h00);
         if (tx_load) sb_check(K_LD, 8'h00, tx_byte);
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_rx(input logic [7:0] b);
      @(posedge clk); #1;
      rx_byte  = b;
      rx_valid = 1'b1;
      @(posedge clk); #1;
      rx_valid = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      idle(GAP);
      pulse_rx(b);
   endtask

   task automatic frame_begin();
      @(posedge clk); #1;
      cs_active = 1'b1;
      idle(3);
   endtask

   task automatic frame_end();
      idle(GAP);
      cs_active = 1'b0;
      idle(3);
   endtask

   task automatic push(input int k, input logic [7:0] a, input logic [7:0] d);
      exp_t e;
      e.kind = k;
      e.addr = a;
      e.data = d;
      sb.push_back(e);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected $finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      idle(2);
      check("rst_tx_byte", {24'd0, tx_byte}, 32'h00);
      check("rst_tx_load", {31'd0, tx_load}, 32'd0);
      check("rst_reg_addr", {25'd0, reg_addr}, 32'd0);
      check("rst_reg_wdata", {24'd0, reg_wdata}, 32'h00);
      check("rst_strobes", {30'd0, reg_we, reg_re}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_ovr_err", {31'd0, ovr_err}, 32'd0);
      rst_n = 1'b1;
      idle(3);

      // Write burst
      frame_begin();
      check("busy_in_frame", {31'd0, busy}, 32'd1);
      send_byte(8'h05);
      push(K_WE, 8'h05, 8'hA1); send_byte(8'hA1);
      push(K_WE, 8'h06, 8'hB2); send_byte(8'hB2);
      push(K_WE, 8'h07, 8'hC3); send_byte(8'hC3);
      frame_end();
      check("busy_after_frame", {31'd0, busy}, 32'd0);

      // Read burst with prefetch and command-to-load latency
      frame_begin();
      idle(GAP);
      push(K_RE, 8'h10, 8'h00); push(K_LD, 8'h00, 8'h3C);
      @(posedge clk); #1;
      rx_byte = 8'h90; rx_valid = 1'b1;
      @(posedge clk); #1;
      rx_valid = 1'b0;
      lat = 1;
      while (lat < 30) begin
         @(negedge clk);
         if (tx_load) break;
         lat++;
      end
      check("cmd_to_load_latency", lat, 2 + RD_LAT);
      push(K_RE, 8'h11, 8'h00); push(K_LD, 8'h00, 8'h5A); send_byte(8'h00);
      push(K_RE, 8'h12, 8'h00); push(K_LD, 8'h00, 8'h77); send_byte(8'h00);
      frame_end();
      check("tx_byte_holds", {24'd0, tx_byte}, 32'h77);

      // Address wrap
      frame_begin();
      send_byte(8'h7F);
      push(K_WE, 8'h7F, 8'h11); send_byte(8'h11);
      push(K_WE, 8'h00, 8'h22); send_byte(8'h22);
      frame_end();

      // Abort after command plus a partial byte, then CS drop racing a byte strobe
      frame_begin();
      send_byte(8'h03);
      idle(4);
      cs_active = 1'b0;
      @(posedge clk); @(negedge clk);
      check("busy_after_abort", {31'd0, busy}, 32'd0);
      idle(3);
      frame_begin();
      send_byte(8'h04);
      push(K_WE, 8'h04, 8'h99); send_byte(8'h99);
      idle(GAP);
      cs_active = 1'b0; rx_byte = 8'h66; rx_valid = 1'b1;
      @(posedge clk); #1;
      rx_valid = 1'b0;
      idle(3);

      // Overrun: sticky flag, explicit clear, and clear winning over set
      frame_begin();
      push(K_RE, 8'h10, 8'h00); push(K_LD, 8'h00, 8'h3C);
      send_byte(8'h90);
      pulse_rx(8'hAA);
      check("ovr_set", {31'd0, ovr_err}, 32'd1);
      idle(GAP);
      check("ovr_sticky", {31'd0, ovr_err}, 32'd1);
      ovr_clr = 1'b1;
      @(posedge clk); #1;
      ovr_clr = 1'b0;
      check("ovr_cleared", {31'd0, ovr_err}, 32'd0);
      push(K_RE, 8'h11, 8'h00); push(K_LD, 8'h00, 8'h5A);
      send_byte(8'h00);
      @(posedge clk); #1;
      rx_byte = 8'hBB; rx_valid = 1'b1; ovr_clr = 1'b1;
      @(posedge clk); #1;
      rx_valid = 1'b0; ovr_clr = 1'b0;
      check("ovr_clr_wins", {31'd0, ovr_err}, 32'd0);
      frame_end();

      // Reset in RD_WAIT, then frame must restart before a command is accepted
      frame_begin();
      push(K_RE, 8'h11, 8'h00);
      send_byte(8'h91);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("midrst_tx_byte", {24'd0, tx_byte}, 32'h00);
      check("midrst_addr", {25'd0, reg_addr}, 32'd0);
      check("midrst_wdata", {24'd0, reg_wdata}, 32'h00);
      check("midrst_strobes", {29'd0, reg_we, reg_re, tx_load}, 32'd0);
      check("midrst_busy", {31'd0, busy}, 32'd0);
      idle(2);
      rst_n = 1'b1;
      idle(5);
      check("no_cmd_after_rst", {31'd0, busy}, 32'd0);
      pulse_rx(8'h06);
      idle(3);
      check("still_idle_after_rst", {31'd0, busy}, 32'd0);
      cs_active = 1'b0;
      idle(3);
      frame_begin();
      send_byte(8'h08);
      push(K_WE, 8'h08, 8'h42); send_byte(8'h42);
      frame_end();

      check("sb_drained", sb.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
